// File: rtl/interval_meter_pkg.sv
// Shared types and constants for the interval meter.
// State encoding and the default counter width.
package interval_meter_pkg;

  localparam int DEF_WIDTH = 5;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_REPORT  = 2'd2
  } state_t;

endpackage

// File: rtl/interval_meter_fsm.sv
// Control FSM for the interval meter.
// Holds state and resolves start/stop priority.
import interval_meter_pkg::*;

module interval_meter_fsm (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic stop,
  input  logic enable,
  output logic busy,
  output logic valid,
  output logic clr_cnt,
  output logic inc_en,
  output logic latch
);

  state_t state;

  always_comb begin
    clr_cnt = 1'b0;
    inc_en  = 1'b0;
    latch   = 1'b0;
    unique case (state)
      S_IDLE: clr_cnt = 1'b1;
      // stop beats a simultaneous start here
      S_MEASURE: begin
        latch   = stop;
        clr_cnt = start & ~stop;
        inc_en  = ~start & ~stop & enable;
      end
      S_REPORT: clr_cnt = 1'b1;
      default:  clr_cnt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          valid <= 1'b0;
          if (start) begin
            state <= S_MEASURE;
            busy  <= 1'b1;
          end
        end
        S_MEASURE: begin
          if (stop) begin
            state <= S_REPORT;
            busy  <= 1'b0;
            valid <= 1'b1;
          end
        end
        S_REPORT: begin
          state <= S_IDLE;
          valid <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/interval_meter.sv
// Counts enabled cycles between start and stop events.
// Saturating counter plus registered result and overflow flag.
import interval_meter_pkg::*;

module interval_meter #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] value,
  output logic             valid,
  output logic             overflow,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic clr_cnt;
  logic inc_en;
  logic latch;
  logic ovf_int;

  interval_meter_fsm u_fsm (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .stop    (stop),
    .enable  (enable),
    .busy    (busy),
    .valid   (valid),
    .clr_cnt (clr_cnt),
    .inc_en  (inc_en),
    .latch   (latch)
  );

  // saturate instead of wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      ovf_int <= 1'b0;
    end else if (clr_cnt) begin
      count   <= '0;
      ovf_int <= 1'b0;
    end else if (inc_en) begin
      if (count == MAX) ovf_int <= 1'b1;
      else              count   <= count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value    <= '0;
      overflow <= 1'b0;
    end else if (latch) begin
      value    <= count;
      overflow <= ovf_int;
    end
  end

endmodule

// File: tb/tb_interval_meter.sv
// Bench for interval_meter: reference model plus directed checks.
// Model tracks an unbounded cycle tally and clips it to the width.
module tb_interval_meter;

  localparam int W   = 5;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] value;
  logic         valid;
  logic         overflow;
  logic         busy;
  logic [W-1:0] count;

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;

  int ph = 0;
  int n = 0;
  int m_value = 0;
  int m_ovf = 0;
  int m_valid = 0;

  interval_meter #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .start    (start),
    .stop     (stop),
    .value    (value),
    .valid    (valid),
    .overflow (overflow),
    .busy     (busy),
    .count    (count)
  );

  always #5 clk = ~clk;

  function automatic int clip(input int x);
    return (x > MAX) ? MAX : x;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph <= 0; n <= 0;
      m_value <= 0; m_ovf <= 0; m_valid <= 0;
    end else begin
      m_valid <= 0;
      case (ph)
        0: if (start) begin ph <= 1; n <= 0; end
        1: begin
          if (stop) begin
            m_value <= clip(n);
            m_ovf   <= (n > MAX) ? 1 : 0;
            m_valid <= 1;
            ph      <= 2;
          end else if (start) n <= 0;
          else if (enable) n <= n + 1;
        end
        default: begin ph <= 0; n <= 0; end
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("m_value", int'(value), m_value);
      chk("m_valid", int'(valid), m_valid);
      chk("m_ovf", int'(overflow), m_ovf);
      chk("m_busy", int'(busy), (ph == 1) ? 1 : 0);
      chk("m_count", int'(count), (ph == 0) ? 0 : clip(n));
    end
  end

  task automatic step(input logic st, input logic sp, input logic en);
    start = st; stop = sp; enable = en;
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name, input int ev, input int eo);
    int k;
    k = 0;
    while (!valid && k < 4) begin
      step(0, 0, 0);
      k++;
    end
    chk({name, "_seen"}, int'(valid), 1);
    chk({name, "_val"}, int'(value), ev);
    chk({name, "_ovf"}, int'(overflow), eo);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    checking = 1'b1;
    @(negedge clk);
    chk("rst_value", int'(value), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_busy", int'(busy), 0);

    step(1, 0, 0);
    chk("t2_busy", int'(busy), 1);
    repeat (7) step(0, 0, 1);
    step(0, 1, 1);
    wait_valid("t2", 7, 0);
    step(0, 0, 0);
    chk("t2_pulse", int'(valid), 0);
    chk("t2_idle", int'(busy), 0);

    step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, (i % 2) == 0);
    step(0, 1, 0);
    wait_valid("t3", 5, 0);
    step(0, 0, 0);
    chk("t3_pulse", int'(valid), 0);

    step(1, 0, 0);
    repeat (40) step(0, 0, 1);
    chk("t4_sat", int'(count), 31);
    step(0, 1, 0);
    wait_valid("t4a", 31, 1);
    step(0, 0, 0);
    step(1, 0, 0);
    repeat (3) step(0, 0, 1);
    step(0, 1, 0);
    wait_valid("t4b", 3, 0);
    step(0, 0, 0);

    step(0, 1, 1);
    chk("t5_stop_valid", int'(valid), 0);
    chk("t5_stop_busy", int'(busy), 0);
    step(1, 1, 1);
    chk("t5_both_busy", int'(busy), 1);
    chk("t5_both_valid", int'(valid), 0);
    repeat (4) step(0, 0, 1);
    step(0, 1, 0);
    wait_valid("t5", 4, 0);
    step(0, 0, 0);

    step(1, 0, 0);
    repeat (6) step(0, 0, 1);
    chk("t6_pre", int'(count), 6);
    reset_n = 1'b0;
    step(0, 0, 1);
    chk("t6_busy", int'(busy), 0);
    chk("t6_count", int'(count), 0);
    chk("t6_valid", int'(valid), 0);
    chk("t6_value", int'(value), 0);
    reset_n = 1'b1;
    repeat (4) step(0, 0, 1);
    chk("t6_after", int'(valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
